microcode_rom: RTL and testbench

//  - Microcode control store for the multi-cycle CPU: 256 words x 40 bits.
//  - The decoder drives the address from opcode + phase offset: +0 DECODE, +64 READ, +128 EXEC. Address 2 is the FETCH word; address 3 is the NOP.
//  - Read is combinational, so the decoder sees the microword in the same state it selects it.
//  - A synchronous patch port lets a loader overwrite words. Reset restores the built-in default microcode.

---
 rtl/microcode_rom_if.sv | 22 ++
 rtl/microcode_rom.sv | 53 +++++
 tb/tb_microcode_rom.sv | 135 +++++++++++++
 3 files changed

// File: rtl/microcode_rom_if.sv
// Control-store bus: combinational read port for the decoder plus a synchronous
// patch port for the microcode loader.
interface microcode_rom_if #(
  parameter int AW = 8,
  parameter int DW = 40
);
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output address, wr_en, wr_addr, wr_data,
    input  data
  );

  modport slave (
    input  address, wr_en, wr_addr, wr_data,
    output data
  );
endinterface

// File: rtl/microcode_rom.sv
// Microcode control store, 256 x 40. Combinational read, synchronous patch writes,
// synchronous reset back to the built-in default microcode.
module microcode_rom #(
  parameter int AW    = 8,
  parameter int DW    = 40,
  parameter int DEPTH = 2**AW
) (
  input  logic            clk,
  input  logic            reset,
  microcode_rom_if.slave  rom_bus
);

  localparam logic [DW-1:0] FETCH_WORD = 40'hC4_7000_0000;
  localparam logic [DW-1:0] NOP_WORD   = 40'h00_0000_0010;

  function automatic logic [DW-1:0] default_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = '0;
    case (a)
      AW'(2):  w = FETCH_WORD;
      AW'(3):  w = NOP_WORD;
      default: w = '0;
    endcase
    return w;
  endfunction

  // Each word is either its default or the last patch written to it. Tracking
  // that with one flag per word makes reset a flag clear, and the flag's
  // declaration value gives the default table at power-up without a reset.
  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_patched = '0;

  logic [DW-1:0]    w_patch_word;
  logic [DW-1:0]    w_default_word;

  always_ff @(posedge clk) begin
    if (reset)
      r_patched <= '0;
    else if (rom_bus.wr_en)
      r_patched[rom_bus.wr_addr] <= 1'b1;
  end

  // Reset discards a simultaneous write; the flag clear hides any stale word.
  always_ff @(posedge clk) begin
    if (!reset && rom_bus.wr_en)
      r_mem[rom_bus.wr_addr] <= rom_bus.wr_data;
  end

  assign w_patch_word   = r_mem[rom_bus.address];
  assign w_default_word = default_word(rom_bus.address);
  assign rom_bus.data   = r_patched[rom_bus.address] ? w_patch_word : w_default_word;

endmodule

// File: tb/tb_microcode_rom.sv
// Directed bench for microcode_rom: power-up defaults, address sweep, patch
// writes, read-during-write ordering and reset priority.
module tb_microcode_rom;
  localparam int AW = 8;
  localparam int DW = 40;

  localparam logic [DW-1:0] FETCH_W = 40'hC4_7000_0000;
  localparam logic [DW-1:0] NOP_W   = 40'h00_0000_0010;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  microcode_rom_if #(.AW(AW), .DW(DW)) rom_bus ();

  microcode_rom #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .rom_bus (rom_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_default(input int a);
    if (a == 2) return FETCH_W;
    if (a == 3) return NOP_W;
    return 40'h0;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int a, input string tag, input logic [DW-1:0] exp);
    rom_bus.address = AW'(a);
    #1;
    chk(tag, rom_bus.data, exp);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b0;
    rom_bus.address = '0;
    rom_bus.wr_en   = 1'b0;
    rom_bus.wr_addr = '0;
    rom_bus.wr_data = '0;

    // Power-up contents, no reset applied yet
    rd(2, "pwrup_a2", FETCH_W);
    rd(3, "pwrup_a3", NOP_W);
    rd(0, "pwrup_a0", 40'h0);

    // Full sweep, same-cycle combinational read
    for (int a = 0; a < 256; a++) rd(a, "sweep", exp_default(a));

    // Write 131: old word before the edge, new word after
    @(negedge clk);
    rom_bus.address = 8'd131;
    rom_bus.wr_en   = 1'b1;
    rom_bus.wr_addr = 8'd131;
    rom_bus.wr_data = 40'hAB_CDEF_0123;
    #1 chk("rdw_before", rom_bus.data, 40'h0);
    @(posedge clk);
    #1 chk("rdw_after", rom_bus.data, 40'hAB_CDEF_0123);
    rom_bus.wr_en = 1'b0;
    rd(130, "neigh_130", 40'h0);
    rd(132, "neigh_132", 40'h0);
    rd(131, "hold_131", 40'hAB_CDEF_0123);

    // Patch FETCH word to zero, then a one-cycle reset restores it
    @(negedge clk);
    rom_bus.wr_en   = 1'b1;
    rom_bus.wr_addr = 8'd2;
    rom_bus.wr_data = 40'h0;
    @(posedge clk);
    #1 rom_bus.wr_en = 1'b0;
    rd(2, "patch_a2", 40'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rd(2, "rst_a2", FETCH_W);
    rd(131, "rst_a131", 40'h0);

    // Reset and write in the same cycle: reset wins, held for three cycles
    @(negedge clk);
    reset           = 1'b1;
    rom_bus.wr_en   = 1'b1;
    rom_bus.wr_addr = 8'd3;
    rom_bus.wr_data = '1;
    rom_bus.address = 8'd3;
    repeat (3) begin
      @(posedge clk);
      #1 chk("rst_wr_a3", rom_bus.data, NOP_W);
    end
    @(negedge clk);
    reset         = 1'b0;
    rom_bus.wr_en = 1'b0;
    rd(3, "rst_wr_a3_after", NOP_W);

    // Back-to-back writes on consecutive cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rom_bus.wr_en   = 1'b1;
      rom_bus.wr_addr = AW'(64 + i);
      rom_bus.wr_data = 40'h11_2233_4400 + DW'(i);
    end
    @(negedge clk);
    rom_bus.wr_en = 1'b0;
    rd(64, "b2b_64", 40'h11_2233_4400);
    rd(65, "b2b_65", 40'h11_2233_4401);
    rd(66, "b2b_66", 40'h11_2233_4402);
    rd(67, "b2b_67", 40'h0);

    // Writing FETCH/NOP is allowed and takes effect
    @(negedge clk);
    rom_bus.wr_en   = 1'b1;
    rom_bus.wr_addr = 8'd3;
    rom_bus.wr_data = 40'h5A_A55A_A5F8;
    @(posedge clk);
    #1 rom_bus.wr_en = 1'b0;
    rd(3, "patch_a3", 40'h5A_A55A_A5F8);
    rd(2, "a2_untouched", FETCH_W);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
